// File: rtl/e203_lpwb_pkg.sv
// e203_lpwb_pkg: shared widths, source indices and scheduler state for the long-pipe writeback scheduler
package e203_lpwb_pkg;
  localparam int E203_ITAG_WIDTH = 2;
  localparam int E203_XLEN = 32;
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_PC_SIZE = 32;
  localparam int LPWB_SRC_LSU = 0;
  localparam int LPWB_SRC_MULDIV = 1;
  typedef enum logic {LPWB_RUN, LPWB_EXCP} lpwb_state_e;
endpackage

// File: rtl/e203_exu_lpwb_sched_if.sv
// e203_exu_lpwb_sched_if: source, OITF, ALU, regfile and exception signals of the long-pipe writeback scheduler
interface e203_exu_lpwb_sched_if import e203_lpwb_pkg::*; #(
  parameter int N_SRC = 2,
  parameter int ITAG_W = E203_ITAG_WIDTH,
  parameter int XLEN = E203_XLEN,
  parameter int RFIDX_W = E203_RFIDX_WIDTH,
  parameter int PC_W = E203_PC_SIZE
);
  logic [N_SRC-1:0] src_i_valid, src_i_ready, src_i_err;
  logic [N_SRC*ITAG_W-1:0] src_i_itag;
  logic [N_SRC*XLEN-1:0] src_i_wdat;
  logic oitf_empty, oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_ena;
  logic [ITAG_W-1:0] oitf_ret_ptr;
  logic [RFIDX_W-1:0] oitf_ret_rdidx;
  logic [PC_W-1:0] oitf_ret_pc;
  logic alu_wbck_i_valid, alu_wbck_i_ready;
  logic [XLEN-1:0] alu_wbck_i_wdat;
  logic [RFIDX_W-1:0] alu_wbck_i_rdidx;
  logic rf_wbck_o_ena, frf_wbck_o_ena;
  logic [XLEN-1:0] rf_wbck_o_wdat, frf_wbck_o_wdat;
  logic [RFIDX_W-1:0] rf_wbck_o_rdidx, frf_wbck_o_rdidx;
  logic lpwb_excp_o_valid, lpwb_excp_o_ready;
  logic [PC_W-1:0] lpwb_excp_o_pc;
  logic lpwb_busy;
  modport slave (
    input src_i_valid, src_i_itag, src_i_wdat, src_i_err,
    input oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_pc,
    input alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx, lpwb_excp_o_ready,
    output src_i_ready, oitf_ret_ena, alu_wbck_i_ready,
    output rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx,
    output frf_wbck_o_ena, frf_wbck_o_wdat, frf_wbck_o_rdidx,
    output lpwb_excp_o_valid, lpwb_excp_o_pc, lpwb_busy
  );
  modport master (
    output src_i_valid, src_i_itag, src_i_wdat, src_i_err,
    output oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_pc,
    output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx, lpwb_excp_o_ready,
    input src_i_ready, oitf_ret_ena, alu_wbck_i_ready,
    input rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx,
    input frf_wbck_o_ena, frf_wbck_o_wdat, frf_wbck_o_rdidx,
    input lpwb_excp_o_valid, lpwb_excp_o_pc, lpwb_busy
  );
endinterface

// File: rtl/e203_lpwb_slot.sv
// e203_lpwb_slot: one-entry holding slot for a long-pipe result; drain and refill may share a cycle
module e203_lpwb_slot import e203_lpwb_pkg::*; #(
  parameter int ITAG_W = E203_ITAG_WIDTH,
  parameter int XLEN = E203_XLEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic [ITAG_W-1:0] in_itag,
  input  logic [XLEN-1:0] in_wdat,
  input  logic in_err,
  input  logic drain,
  output logic ready,
  output logic vld,
  output logic [ITAG_W-1:0] itag,
  output logic [XLEN-1:0] wdat,
  output logic err
);
  assign ready = ~vld | drain;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= 1'b0;
      itag <= '0;
      wdat <= '0;
      err <= 1'b0;
    end else if (in_valid & ready) begin
      vld <= 1'b1;
      itag <= in_itag;
      wdat <= in_wdat;
      err <= in_err;
    end else if (drain) begin
      vld <= 1'b0;
    end
endmodule

// File: rtl/e203_exu_lpwb_sched.sv
// e203_exu_lpwb_sched: in-order long-pipe retirement against the OITF head, sharing the integer write port with the ALU.
// E203_LPWB_BYPASS_EN retires a matching error-free result in its arrival cycle when no slot hits.
module e203_exu_lpwb_sched import e203_lpwb_pkg::*; #(
  parameter int N_SRC = 2,
  parameter int ITAG_W = E203_ITAG_WIDTH,
  parameter int XLEN = E203_XLEN,
  parameter int RFIDX_W = E203_RFIDX_WIDTH,
  parameter int PC_W = E203_PC_SIZE
) (
  input logic clk,
  input logic rst_n,
  e203_exu_lpwb_sched_if.slave io
);
  localparam int IDX_W = N_SRC > 1 ? $clog2(N_SRC) : 1;
  lpwb_state_e state;
  logic excp_vld;
  logic [PC_W-1:0] excp_pc;
  logic [IDX_W-1:0] excp_idx, sel, byp_sel;
  logic [N_SRC-1:0] slot_vld, slot_err, slot_drain, hit, byp_cand;
  logic [ITAG_W-1:0] slot_itag [N_SRC];
  logic [ITAG_W-1:0] src_itag [N_SRC];
  logic [XLEN-1:0] slot_wdat [N_SRC];
  logic [XLEN-1:0] src_wdat [N_SRC];
  logic run, any_hit, lp_go, byp_go, lp_ret, lp_int, lp_fp, excp_hs;
  logic [XLEN-1:0] lp_wdat;
  for (genvar g = 0; g < N_SRC; g++) begin : g_slot
    assign src_itag[g] = io.src_i_itag[g*ITAG_W +: ITAG_W];
    assign src_wdat[g] = io.src_i_wdat[g*XLEN +: XLEN];
    assign hit[g] = slot_vld[g] & ~io.oitf_empty & (slot_itag[g] == io.oitf_ret_ptr);
    assign slot_drain[g] = (lp_go & (sel == IDX_W'(g))) | (excp_hs & (excp_idx == IDX_W'(g)));
`ifdef E203_LPWB_BYPASS_EN
    assign byp_cand[g] = io.src_i_valid[g] & ~slot_vld[g] & ~io.oitf_empty & ~io.src_i_err[g] & (src_itag[g] == io.oitf_ret_ptr);
`else
    assign byp_cand[g] = 1'b0;
`endif
    e203_lpwb_slot #(.ITAG_W(ITAG_W), .XLEN(XLEN)) u_slot (
      .clk(clk), .rst_n(rst_n),
      .in_valid(io.src_i_valid[g] & ~(byp_go & (byp_sel == IDX_W'(g)))),
      .in_itag(src_itag[g]), .in_wdat(src_wdat[g]), .in_err(io.src_i_err[g]),
      .drain(slot_drain[g]), .ready(io.src_i_ready[g]),
      .vld(slot_vld[g]), .itag(slot_itag[g]), .wdat(slot_wdat[g]), .err(slot_err[g])
    );
  end
  // Descending scan leaves the lowest matching index selected.
  always_comb begin
    sel = '0;
    byp_sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      sel = hit[i] ? IDX_W'(i) : sel;
      byp_sel = byp_cand[i] ? IDX_W'(i) : byp_sel;
    end
  end
  assign run = state == LPWB_RUN;
  assign any_hit = |hit;
  assign lp_go = run & any_hit & ~slot_err[sel];
  assign byp_go = run & ~any_hit & |byp_cand;
  assign lp_ret = lp_go | byp_go;
  assign lp_wdat = byp_go ? src_wdat[byp_sel] : slot_wdat[sel];
  assign lp_int = lp_ret & io.oitf_ret_rdwen & ~io.oitf_ret_rdfpu;
  assign lp_fp = lp_ret & io.oitf_ret_rdwen & io.oitf_ret_rdfpu;
  assign excp_hs = excp_vld & io.lpwb_excp_o_ready;
  assign io.oitf_ret_ena = lp_ret | excp_hs;
  assign io.alu_wbck_i_ready = ~lp_int;
  assign io.rf_wbck_o_ena = lp_int | io.alu_wbck_i_valid;
  assign io.rf_wbck_o_wdat = lp_int ? lp_wdat : io.alu_wbck_i_wdat;
  assign io.rf_wbck_o_rdidx = lp_int ? io.oitf_ret_rdidx : io.alu_wbck_i_rdidx;
  assign io.frf_wbck_o_ena = lp_fp;
  assign io.frf_wbck_o_wdat = lp_wdat;
  assign io.frf_wbck_o_rdidx = io.oitf_ret_rdidx;
  assign io.lpwb_excp_o_valid = excp_vld;
  assign io.lpwb_excp_o_pc = excp_pc;
  assign io.lpwb_busy = |slot_vld | ~run;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LPWB_RUN;
      excp_vld <= 1'b0;
      excp_pc <= '0;
      excp_idx <= '0;
    end else if (run) begin
      if (any_hit & slot_err[sel]) begin
        state <= LPWB_EXCP;
        excp_vld <= 1'b1;
        excp_pc <= io.oitf_ret_pc;
        excp_idx <= sel;
      end
    end else if (io.lpwb_excp_o_ready) begin
      state <= LPWB_RUN;
      excp_vld <= 1'b0;
    end
  a_one_hit: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hit));
  a_vld_empty: assert property (@(posedge clk) disable iff (!rst_n) !((|slot_vld) && io.oitf_empty));
endmodule

// File: tb/tb_e203_exu_lpwb_sched.sv
// tb_e203_exu_lpwb_sched: directed stimulus, OITF queue model with per-cycle scoreboard compare and literal spot checks
module tb_e203_exu_lpwb_sched;
  import e203_lpwb_pkg::*;
  localparam int N = 2;
  localparam int TW = E203_ITAG_WIDTH;
  localparam int XW = E203_XLEN;
  localparam int RW = E203_RFIDX_WIDTH;
  localparam int PW = E203_PC_SIZE;
  typedef struct {
    logic [TW-1:0] tag;
    logic [RW-1:0] rd;
    logic wen;
    logic fpu;
    logic [PW-1:0] pc;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  ent_t q[$];
  logic [N-1:0] pv = '0;
  logic [N-1:0] perr = '0;
  logic [TW-1:0] ptag [N];
  logic [XW-1:0] pdat [N];
  logic exc = 1'b0;
  int esrc = 0;
  logic [PW-1:0] epc = '0;
  e203_exu_lpwb_sched_if #(.N_SRC(N), .ITAG_W(TW), .XLEN(XW), .RFIDX_W(RW), .PC_W(PW)) io ();
  e203_exu_lpwb_sched #(.N_SRC(N), .ITAG_W(TW), .XLEN(XW), .RFIDX_W(RW), .PC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .io(io)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic nx;
    @(posedge clk);
    #2;
    io.src_i_valid = '0;
    io.src_i_err = '0;
    io.alu_wbck_i_valid = 1'b0;
    io.lpwb_excp_o_ready = 1'b0;
  endtask
  task automatic src(input int k, input logic [TW-1:0] t, input logic [XW-1:0] d, input logic e);
    io.src_i_valid[k] = 1'b1;
    io.src_i_itag[k*TW +: TW] = t;
    io.src_i_wdat[k*XW +: XW] = d;
    io.src_i_err[k] = e;
  endtask
  task automatic alu(input logic [XW-1:0] d, input logic [RW-1:0] r);
    io.alu_wbck_i_valid = 1'b1;
    io.alu_wbck_i_wdat = d;
    io.alu_wbck_i_rdidx = r;
  endtask
  task automatic push(input logic [TW-1:0] t, input logic [RW-1:0] r, input logic w, input logic f, input logic [PW-1:0] pc);
    ent_t e;
    e.tag = t; e.rd = r; e.wen = w; e.fpu = f; e.pc = pc;
    q.push_back(e);
  endtask
  // OITF head presented to the DUT a moment after each edge
  always @(posedge clk) begin
    #1;
    io.oitf_empty = q.size() == 0;
    if (q.size() > 0) begin
      io.oitf_ret_ptr = q[0].tag;
      io.oitf_ret_rdidx = q[0].rd;
      io.oitf_ret_rdwen = q[0].wen;
      io.oitf_ret_rdfpu = q[0].fpu;
      io.oitf_ret_pc = q[0].pc;
    end
  end
  always @(negedge clk) begin : model
    int hk, bk;
    logic ret, lpi, lpf, ev, busy, rfe;
    logic [XW-1:0] d;
    logic [N-1:0] rdy;
    ent_t h;
    if (!rst_n) begin
      pv = '0;
      exc = 1'b0;
    end else begin
      hk = -1; bk = -1; ret = 0; lpi = 0; lpf = 0; d = '0;
      rdy = ~pv; ev = exc; busy = (|pv) | exc;
      h.tag = '0; h.rd = '0; h.wen = 0; h.fpu = 0; h.pc = '0;
      if (q.size() > 0) h = q[0];
      if (exc) begin
        if (io.lpwb_excp_o_ready) begin
          ret = 1; pv[esrc] = 0; rdy[esrc] = 1; exc = 0;
        end
      end else if (q.size() > 0) begin
        for (int k = N - 1; k >= 0; k--) if (pv[k] && ptag[k] == h.tag) hk = k;
`ifdef E203_LPWB_BYPASS_EN
        if (hk < 0)
          for (int k = N - 1; k >= 0; k--)
            if (io.src_i_valid[k] && !pv[k] && !io.src_i_err[k] && io.src_i_itag[k*TW +: TW] == h.tag) bk = k;
`endif
        if (hk >= 0 && perr[hk]) begin
          exc = 1; esrc = hk; epc = h.pc;
        end else if (hk >= 0 || bk >= 0) begin
          ret = 1;
          if (hk >= 0) begin
            d = pdat[hk]; pv[hk] = 0; rdy[hk] = 1;
          end else d = io.src_i_wdat[bk*XW +: XW];
          lpi = h.wen && !h.fpu;
          lpf = h.wen && h.fpu;
        end
      end
      rfe = lpi | io.alu_wbck_i_valid;
      chk("ret_ena", io.oitf_ret_ena, ret);
      chk("src_ready", io.src_i_ready, rdy);
      chk("alu_ready", io.alu_wbck_i_ready, !lpi);
      chk("rf_ena", io.rf_wbck_o_ena, rfe);
      if (rfe) begin
        chk("rf_wdat", io.rf_wbck_o_wdat, lpi ? d : io.alu_wbck_i_wdat);
        chk("rf_rdidx", io.rf_wbck_o_rdidx, lpi ? h.rd : io.alu_wbck_i_rdidx);
      end
      chk("frf_ena", io.frf_wbck_o_ena, lpf);
      if (lpf) begin
        chk("frf_wdat", io.frf_wbck_o_wdat, d);
        chk("frf_rdidx", io.frf_wbck_o_rdidx, h.rd);
      end
      chk("excp_valid", io.lpwb_excp_o_valid, ev);
      if (ev) chk("excp_pc", io.lpwb_excp_o_pc, epc);
      chk("busy", io.lpwb_busy, busy);
      if (ret) void'(q.pop_front());
      for (int k = 0; k < N; k++)
        if (io.src_i_valid[k] && rdy[k] && k != bk) begin
          pv[k] = 1;
          ptag[k] = io.src_i_itag[k*TW +: TW];
          pdat[k] = io.src_i_wdat[k*XW +: XW];
          perr[k] = io.src_i_err[k];
        end
    end
  end
  initial begin
    io.src_i_valid = '0; io.src_i_err = '0; io.src_i_itag = '0; io.src_i_wdat = '0;
    io.oitf_empty = 1'b1; io.oitf_ret_ptr = '0; io.oitf_ret_rdidx = '0;
    io.oitf_ret_rdwen = 1'b0; io.oitf_ret_rdfpu = 1'b0; io.oitf_ret_pc = '0;
    io.alu_wbck_i_valid = 1'b0; io.alu_wbck_i_wdat = '0; io.alu_wbck_i_rdidx = '0;
    io.lpwb_excp_o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", io.src_i_ready, 2'b11);
    chk("rst_excp_pc", io.lpwb_excp_o_pc, 0);
    chk("rst_busy", io.lpwb_busy, 0);
    // out-of-order return: src1 carries tag1 first, src0 tag0 one cycle later
    push(0, 5, 1, 0, 32'h100);
    push(1, 5, 1, 0, 32'h104);
    nx;
    src(1, 1, 32'h11, 0);
    @(negedge clk);
    chk("ooo_ready_a", io.src_i_ready, 2'b11);
    nx;
    src(0, 0, 32'h22, 0);
    @(negedge clk);
    chk("ooo_ready1_b", io.src_i_ready[1], 0);
`ifdef E203_LPWB_BYPASS_EN
    chk("ooo_byp_wdat", io.rf_wbck_o_wdat, 32'h22);
    chk("ooo_byp_ret", io.oitf_ret_ena, 1);
`endif
    nx;
    @(negedge clk);
`ifdef E203_LPWB_BYPASS_EN
    chk("ooo_c_wdat", io.rf_wbck_o_wdat, 32'h11);
`else
    chk("ooo_c_wdat", io.rf_wbck_o_wdat, 32'h22);
    chk("ooo_c_rdidx", io.rf_wbck_o_rdidx, 5);
    chk("ooo_c_ret", io.oitf_ret_ena, 1);
    chk("ooo_c_ready1", io.src_i_ready[1], 0);
    nx;
    @(negedge clk);
    chk("ooo_d_wdat", io.rf_wbck_o_wdat, 32'h11);
    chk("ooo_d_ret", io.oitf_ret_ena, 1);
`endif
    nx;
    // long-pipe integer write beats ALU, ALU follows next cycle
    push(2, 5, 1, 0, 32'h108);
    nx;
    src(0, 2, 32'h55, 0);
`ifndef E203_LPWB_BYPASS_EN
    @(negedge clk);
    chk("prio_hold", io.rf_wbck_o_ena, 0);
    nx;
`endif
    alu(32'h33, 7);
    @(negedge clk);
    chk("prio_wdat", io.rf_wbck_o_wdat, 32'h55);
    chk("prio_alu_rdy", io.alu_wbck_i_ready, 0);
    nx;
    alu(32'h33, 7);
    @(negedge clk);
    chk("alu_wdat", io.rf_wbck_o_wdat, 32'h33);
    chk("alu_rdidx", io.rf_wbck_o_rdidx, 7);
    chk("alu_rdy", io.alu_wbck_i_ready, 1);
    nx;
    // error result: exception held for three cycles before the handshake
    push(3, 6, 1, 0, 32'h8000_0010);
    nx;
    src(1, 3, 32'h66, 1);
    @(negedge clk);
    nx;
    @(negedge clk);
    chk("err_sel_ret", io.oitf_ret_ena, 0);
    chk("err_sel_rf", io.rf_wbck_o_ena, 0);
    nx;
    repeat (3) begin
      @(negedge clk);
      chk("excp_hold_vld", io.lpwb_excp_o_valid, 1);
      chk("excp_hold_pc", io.lpwb_excp_o_pc, 32'h8000_0010);
      chk("excp_hold_ret", io.oitf_ret_ena, 0);
      nx;
    end
    io.lpwb_excp_o_ready = 1'b1;
    @(negedge clk);
    chk("excp_hs_ret", io.oitf_ret_ena, 1);
    nx;
    @(negedge clk);
    chk("excp_done", io.lpwb_excp_o_valid, 0);
    nx;
    // rdwen=0 retirement alongside an ALU write
    push(0, 9, 0, 0, 32'h200);
    nx;
    src(0, 0, 32'h77, 0);
`ifndef E203_LPWB_BYPASS_EN
    @(negedge clk);
    nx;
`endif
    alu(32'h88, 10);
    @(negedge clk);
    chk("nowen_ret", io.oitf_ret_ena, 1);
    chk("nowen_alu_rdy", io.alu_wbck_i_ready, 1);
    chk("nowen_rf", io.rf_wbck_o_wdat, 32'h88);
    nx;
    // FP writeback in parallel with an ALU integer write
    push(1, 11, 1, 1, 32'h204);
    nx;
    src(1, 1, 32'h99, 0);
`ifndef E203_LPWB_BYPASS_EN
    @(negedge clk);
    nx;
`endif
    alu(32'hAA, 12);
    @(negedge clk);
    chk("fp_ena", io.frf_wbck_o_ena, 1);
    chk("fp_wdat", io.frf_wbck_o_wdat, 32'h99);
    chk("fp_rdidx", io.frf_wbck_o_rdidx, 11);
    chk("fp_alu_wdat", io.rf_wbck_o_wdat, 32'hAA);
    chk("fp_alu_rdidx", io.rf_wbck_o_rdidx, 12);
    nx;
    // arrival-cycle retirement only with the bypass built in
    push(2, 5, 1, 0, 32'h208);
    nx;
    src(0, 2, 32'h44, 0);
    @(negedge clk);
`ifdef E203_LPWB_BYPASS_EN
    chk("byp_wdat", io.rf_wbck_o_wdat, 32'h44);
    chk("byp_ret", io.oitf_ret_ena, 1);
`else
    chk("nobyp_rf", io.rf_wbck_o_ena, 0);
    chk("nobyp_ret", io.oitf_ret_ena, 0);
    nx;
    @(negedge clk);
    chk("nobyp_wdat", io.rf_wbck_o_wdat, 32'h44);
    chk("nobyp_ret2", io.oitf_ret_ena, 1);
`endif
    nx;
    // reset while in exception with the other slot occupied
    push(3, 1, 1, 0, 32'h1234);
    push(0, 2, 1, 0, 32'h1238);
    nx;
    src(0, 3, 32'hEE, 1);
    src(1, 0, 32'hDD, 0);
    @(negedge clk);
    nx;
    @(negedge clk);
    nx;
    @(negedge clk);
    chk("pre_rst_excp", io.lpwb_excp_o_valid, 1);
    nx;
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    nx;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", io.src_i_ready, 2'b11);
    chk("mid_rst_ret", io.oitf_ret_ena, 0);
    chk("mid_rst_excp", io.lpwb_excp_o_valid, 0);
    chk("mid_rst_pc", io.lpwb_excp_o_pc, 0);
    chk("mid_rst_busy", io.lpwb_busy, 0);
    nx;
    repeat (2) nx;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
